register_file_sequencer: RTL and testbench
==========================================

REGISTER_FILE_SEQUENCER -- requirements
Module: register_file_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports CmdValid in 1 / CmdReady out 1: command handshake; transfer when both high at a rising edge.
REQ-004 SHALL have port CmdOp, input, 3, operation: 000 NOP, 001 LDI, 010 MOV, 011 CLR, 100 INC, 101 DEC, 110 SWP, 111 RD.
REQ-005 SHALL have ports CmdDst in 3 / CmdSrc in 3: register code (000-011 R1-R4, 100-111 S1-S4).
REQ-006 SHALL have port CmdImm, input, 16, immediate for LDI.
REQ-007 SHALL have ports OutA in 16 / OutB in 16: read data returned by the register file.
REQ-008 SHALL have ports OutASel out 3, OutBSel out 3, FunSel out 3, RegSel out 4, ScrSel out 4, I out 16: register-file control and write data.
REQ-009 SHALL have ports ReadData out 16 (RD result) and Done out 1 (one-cycle completion pulse).

Function
REQ-010 SHALL implement states IDLE, EXEC, CAPT, WR1, WR2, RESP.
REQ-011 SHALL assert CmdReady only in IDLE; CmdValid outside IDLE is ignored and produces no side effect.
REQ-012 SHALL on handshake latch CmdOp/CmdDst/CmdSrc/CmdImm and go IDLE->CAPT for SWP, IDLE->EXEC otherwise.
REQ-013 SHALL go EXEC->RESP, CAPT->WR1->WR2->RESP, RESP->IDLE, one cycle each.
REQ-014 SHALL assert Done high exactly in RESP; latency accept-edge to Done = 2 cycles (non-SWP), 4 cycles (SWP).
REQ-015 SHALL drive RegSel=ScrSel=4'b1111, FunSel=010, I=0, OutASel=CmdSrc latched, OutBSel=CmdDst latched in every state without a write.
REQ-016 SHALL decode a write target t as: t<100 -> RegSel bit (3-t) low; t>=100 -> ScrSel bit (7-t) low; exactly one enable low per write cycle, other group 4'b1111.
REQ-017 SHALL in EXEC: LDI FunSel=010, I=CmdImm, enable dst; MOV FunSel=010, OutASel=src, I=OutA, enable dst; CLR FunSel=011; INC FunSel=001; DEC FunSel=000; NOP and RD no enable.
REQ-018 SHALL for RD in EXEC drive OutASel=src and load ReadData<=OutA at end of EXEC; ReadData otherwise holds.
REQ-019 SHALL for SWP in CAPT drive OutASel=src, OutBSel=dst, load internal TempA<=OutA, TempB<=OutB.
REQ-020 SHALL for SWP in WR1 write dst with FunSel=010, I=TempA; in WR2 write src with FunSel=010, I=TempB.
REQ-021 SHALL treat SWP with src==dst and MOV with src==dst as legal: full timing, value unchanged.
REQ-022 SHALL ignore CmdSrc for LDI/CLR/INC/DEC/NOP and CmdDst for RD/NOP.
REQ-023 SHALL derive all register-file control outputs combinationally from state and latched command only (no dependence on live Cmd* inputs).
REQ-024 SHALL allow a new command accepted in IDLE the cycle after RESP (back-to-back throughput 3 cycles non-SWP).

Reset
REQ-025 SHALL on Reset low immediately force IDLE, CmdReady=1, Done=0, ReadData=0, TempA=TempB=0, latched command=0, RegSel=ScrSel=4'b1111, FunSel=010, I=0.
REQ-026 SHALL on Reset asserted mid-operation (any state) abort with no further write; a SWP aborted after WR1 leaves dst written, src unmodified.
REQ-027 SHALL accept commands from the first rising edge after Reset deasserts.

Verification
REQ-028 SHALL check LDI dst=010 imm=16'hA5A5 -> EXEC: RegSel=1101, FunSel=010, I=A5A5; Done 2 cycles after accept; RD src=010 then returns ReadData=A5A5.
REQ-029 SHALL check SWP src=000 dst=101 with R1=1234, S2=BEEF -> CAPT latches both; WR1 ScrSel=1011 I=1234; WR2 RegSel=0111 I=BEEF; Done at cycle 4.
REQ-030 SHALL check CmdValid held high during busy states -> CmdReady=0, second command accepted only in IDLE after Done, no extra write.
REQ-031 SHALL check INC dst=111 then DEC dst=111 back-to-back -> ScrSel=1110 with FunSel=001 then 000, accepts 3 cycles apart.
REQ-032 SHALL check Reset pulsed low during SWP WR1 -> enables high immediately, ReadData=0, state IDLE, src untouched.
REQ-033 SHALL check MOV src=100 dst=100 and NOP -> full timing, NOP shows no enable low in any cycle.

Source files
------------

// File: rtl/register_file_sequencer.sv
// Command sequencer for an 8-entry register file (R1-R4, S1-S4): decodes one
// command at a time into register-file control, including a two-write swap.
module register_file_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        CmdValid,
   output logic        CmdReady,
   input  logic [2:0]  CmdOp,
   input  logic [2:0]  CmdDst,
   input  logic [2:0]  CmdSrc,
   input  logic [15:0] CmdImm,
   input  logic [15:0] OutA,
   input  logic [15:0] OutB,
   output logic [2:0]  OutASel,
   output logic [2:0]  OutBSel,
   output logic [2:0]  FunSel,
   output logic [3:0]  RegSel,
   output logic [3:0]  ScrSel,
   output logic [15:0] I,
   output logic [15:0] ReadData,
   output logic        Done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_EXEC = 3'd1;
   localparam logic [2:0] S_CAPT = 3'd2;
   localparam logic [2:0] S_WR1  = 3'd3;
   localparam logic [2:0] S_WR2  = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_MOV = 3'b010;
   localparam logic [2:0] OP_CLR = 3'b011;
   localparam logic [2:0] OP_INC = 3'b100;
   localparam logic [2:0] OP_DEC = 3'b101;
   localparam logic [2:0] OP_SWP = 3'b110;
   localparam logic [2:0] OP_RD  = 3'b111;

   localparam logic [2:0] FUN_DEC  = 3'b000;
   localparam logic [2:0] FUN_INC  = 3'b001;
   localparam logic [2:0] FUN_LOAD = 3'b010;
   localparam logic [2:0] FUN_CLR  = 3'b011;

   logic [2:0]  r_state;
   logic [2:0]  r_op;
   logic [2:0]  r_dst;
   logic [2:0]  r_src;
   logic [15:0] r_imm;
   logic [15:0] r_temp_a;
   logic [15:0] r_temp_b;
   logic [15:0] r_read_data;

   logic [2:0]  w_next;
   logic [7:0]  w_en;
   logic        w_accept;

   // {RegSel,ScrSel} as one active-low vector: code t clears bit 7-t, which
   // lands on RegSel[3-t] for R1-R4 and ScrSel[7-t] for S1-S4.
   function automatic logic [7:0] f_enable(input logic [2:0] t);
      return ~(8'h80 >> t);
   endfunction

   assign CmdReady = (r_state == S_IDLE);
   assign Done     = (r_state == S_RESP);
   assign w_accept = CmdValid && CmdReady;
   assign ReadData = r_read_data;
   assign RegSel   = w_en[7:4];
   assign ScrSel   = w_en[3:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = (CmdOp == OP_SWP) ? S_CAPT : S_EXEC;
         S_EXEC:  w_next = S_RESP;
         S_CAPT:  w_next = S_WR1;
         S_WR1:   w_next = S_WR2;
         S_WR2:   w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Control depends only on state and the latched command, never live Cmd*.
   always_comb begin
      w_en    = 8'hFF;
      FunSel  = FUN_LOAD;
      I       = 16'h0000;
      OutASel = r_src;
      OutBSel = r_dst;
      case (r_state)
         S_EXEC: begin
            case (r_op)
               OP_LDI: begin w_en = f_enable(r_dst); I = r_imm; end
               OP_MOV: begin w_en = f_enable(r_dst); I = OutA; end
               OP_CLR: begin w_en = f_enable(r_dst); FunSel = FUN_CLR; end
               OP_INC: begin w_en = f_enable(r_dst); FunSel = FUN_INC; end
               OP_DEC: begin w_en = f_enable(r_dst); FunSel = FUN_DEC; end
               default: ;
            endcase
         end
         S_WR1: begin w_en = f_enable(r_dst); I = r_temp_a; end
         S_WR2: begin w_en = f_enable(r_src); I = r_temp_b; end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state     <= S_IDLE;
         r_op        <= 3'b000;
         r_dst       <= 3'b000;
         r_src       <= 3'b000;
         r_imm       <= 16'h0000;
         r_temp_a    <= 16'h0000;
         r_temp_b    <= 16'h0000;
         r_read_data <= 16'h0000;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op  <= CmdOp;
            r_dst <= CmdDst;
            r_src <= CmdSrc;
            r_imm <= CmdImm;
         end
         if (r_state == S_EXEC && r_op == OP_RD) r_read_data <= OutA;
         // Both operands are captured before either write so src==dst is harmless.
         if (r_state == S_CAPT) begin
            r_temp_a <= OutA;
            r_temp_b <= OutB;
         end
      end
   end

endmodule

// File: tb/tb_register_file_sequencer.sv
// Bench for register_file_sequencer: register-file model on the DUT's control
// outputs, directed vector table, hand-written corner sequences, random commands.
module tb_register_file_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        CmdValid = 1'b0;
   logic        CmdReady;
   logic [2:0]  CmdOp = 3'd0, CmdDst = 3'd0, CmdSrc = 3'd0;
   logic [15:0] CmdImm = 16'h0;
   logic [15:0] OutA, OutB;
   logic [2:0]  OutASel, OutBSel, FunSel;
   logic [3:0]  RegSel, ScrSel;
   logic [15:0] I;
   logic [15:0] ReadData;
   logic        Done;

   register_file_sequencer dut (
      .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdOp(CmdOp), .CmdDst(CmdDst), .CmdSrc(CmdSrc), .CmdImm(CmdImm),
      .OutA(OutA), .OutB(OutB), .OutASel(OutASel), .OutBSel(OutBSel),
      .FunSel(FunSel), .RegSel(RegSel), .ScrSel(ScrSel), .I(I),
      .ReadData(ReadData), .Done(Done)
   );

   always #5 Clock = ~Clock;

   // Register file the sequencer drives; index = register code.
   logic [15:0] rf [8] = '{default: 16'h0};
   assign OutA = rf[OutASel];
   assign OutB = rf[OutBSel];

   function automatic logic [15:0] rf_next(input logic [15:0] old);
      case (FunSel)
         3'b000:  return old - 16'd1;
         3'b001:  return old + 16'd1;
         3'b010:  return I;
         3'b011:  return 16'h0;
         default: return old;
      endcase
   endfunction

   always @(posedge Clock) begin
      for (int k = 0; k < 4; k++) begin
         if (!RegSel[3-k]) rf[k]   <= rf_next(rf[k]);
         if (!ScrSel[3-k]) rf[4+k] <= rf_next(rf[4+k]);
      end
   end

   int cyc = 0, acc_cnt = 0, acc_last = 0, acc_prev = 0;
   always @(posedge Clock) begin
      cyc <= cyc + 1;
      if (CmdValid && CmdReady) begin
         acc_cnt  <= acc_cnt + 1;
         acc_prev <= acc_last;
         acc_last <= cyc;
      end
   end

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Architectural reference: effect of each whole command, nothing cycle-level.
   logic [15:0] ref_rf [8] = '{default: 16'h0};
   logic [15:0] ref_rd = 16'h0;

   task automatic apply_ref(input logic [2:0] op, dst, src, input logic [15:0] imm);
      logic [15:0] t;
      case (op)
         3'b001: ref_rf[dst] = imm;
         3'b010: ref_rf[dst] = ref_rf[src];
         3'b011: ref_rf[dst] = 16'h0;
         3'b100: ref_rf[dst] = ref_rf[dst] + 16'd1;
         3'b101: ref_rf[dst] = ref_rf[dst] - 16'd1;
         3'b110: begin t = ref_rf[dst]; ref_rf[dst] = ref_rf[src]; ref_rf[src] = t; end
         3'b111: ref_rd = ref_rf[src];
         default: ;
      endcase
   endtask

   function automatic int exp_lat(input logic [2:0] op);
      return (op == 3'b110) ? 4 : 2;
   endfunction

   function automatic int exp_wr(input logic [2:0] op);
      if (op == 3'b000 || op == 3'b111) return 0;
      return (op == 3'b110) ? 2 : 1;
   endfunction

   // Per-cycle samples after the accept edge (index 1 = first cycle).
   logic [3:0]  s_reg [9];
   logic [3:0]  s_scr [9];
   logic [2:0]  s_fun [9];
   logic [15:0] s_i   [9];
   logic [2:0]  s_asel[9];
   logic [2:0]  s_bsel[9];
   int s_lat, s_wr, s_multi, s_wait;

   // Called at a falling edge; returns at a falling edge with the DUT idle.
   task automatic issue(input logic [2:0] op, dst, src, input logic [15:0] imm);
      int  zeros;
      bit  seen;
      s_wait = 0;
      while (!CmdReady && s_wait < 20) begin @(negedge Clock); s_wait++; end
      if (!CmdReady) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got CmdReady=0 expected 1");
         return;
      end
      CmdOp = op; CmdDst = dst; CmdSrc = src; CmdImm = imm; CmdValid = 1'b1;
      @(posedge Clock); #1 CmdValid = 1'b0;
      s_lat = 0; s_wr = 0; s_multi = 0; seen = 0;
      for (int c = 1; c <= 8 && !seen; c++) begin
         @(negedge Clock);
         s_reg[c] = RegSel; s_scr[c] = ScrSel; s_fun[c] = FunSel; s_i[c] = I;
         s_asel[c] = OutASel; s_bsel[c] = OutBSel;
         zeros = $countones(~{RegSel, ScrSel});
         if (zeros > 0) s_wr++;
         if (zeros > 1) s_multi++;
         s_lat = c;
         if (Done) seen = 1;
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL done_timeout: got no Done expected Done within 8 cycles");
      end
      @(negedge Clock);
      chk("done_one_cycle", {31'd0, Done}, 32'd0);
      apply_ref(op, dst, src, imm);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!CmdReady && n < 20) begin @(negedge Clock); n++; end
      chk("wait_idle", {31'd0, CmdReady}, 32'd1);
   endtask

   typedef struct packed {
      logic [2:0]  op, dst, src;
      logic [15:0] imm;
      logic [3:0]  reg_sel, scr_sel;
      logic [2:0]  fun;
      logic [15:0] i_val, rd;
   } vec_t;

   vec_t tbl [12];
   logic [15:0] v0, v1;
   logic [2:0]  rop, rdst, rsrc;
   logic [15:0] rimm;

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before 300us");
      $fatal(1, "watchdog");
   end

   initial begin
      //            op     dst    src    imm      reg    scr    fun    I        RD
      tbl[0]  = '{3'd1, 3'd2, 3'd0, 16'hA5A5, 4'hD, 4'hF, 3'd2, 16'hA5A5, 16'h0};
      tbl[1]  = '{3'd7, 3'd0, 3'd2, 16'h0000, 4'hF, 4'hF, 3'd2, 16'h0000, 16'hA5A5};
      tbl[2]  = '{3'd1, 3'd5, 3'd0, 16'hBEEF, 4'hF, 4'hB, 3'd2, 16'hBEEF, 16'h0};
      tbl[3]  = '{3'd2, 3'd0, 3'd5, 16'h0000, 4'h7, 4'hF, 3'd2, 16'hBEEF, 16'h0};
      tbl[4]  = '{3'd1, 3'd4, 3'd6, 16'h1357, 4'hF, 4'h7, 3'd2, 16'h1357, 16'h0};
      tbl[5]  = '{3'd2, 3'd4, 3'd4, 16'h0000, 4'hF, 4'h7, 3'd2, 16'h1357, 16'h0};
      tbl[6]  = '{3'd4, 3'd7, 3'd1, 16'h0000, 4'hF, 4'hE, 3'd1, 16'h0000, 16'h0};
      tbl[7]  = '{3'd5, 3'd7, 3'd1, 16'h0000, 4'hF, 4'hE, 3'd0, 16'h0000, 16'h0};
      tbl[8]  = '{3'd3, 3'd2, 3'd3, 16'hFFFF, 4'hD, 4'hF, 3'd3, 16'h0000, 16'h0};
      tbl[9]  = '{3'd0, 3'd6, 3'd3, 16'h7777, 4'hF, 4'hF, 3'd2, 16'h0000, 16'h0};
      tbl[10] = '{3'd7, 3'd3, 3'd0, 16'h0000, 4'hF, 4'hF, 3'd2, 16'h0000, 16'hBEEF};
      tbl[11] = '{3'd7, 3'd1, 3'd2, 16'h0000, 4'hF, 4'hF, 3'd2, 16'h0000, 16'h0000};

      // Reset state
      repeat (3) @(negedge Clock);
      chk("rst_ready", {31'd0, CmdReady}, 32'd1);
      chk("rst_done", {31'd0, Done}, 32'd0);
      chk("rst_readdata", {16'd0, ReadData}, 32'd0);
      chk("rst_regsel", {28'd0, RegSel}, 32'hF);
      chk("rst_scrsel", {28'd0, ScrSel}, 32'hF);
      chk("rst_funsel", {29'd0, FunSel}, 32'd2);
      chk("rst_i", {16'd0, I}, 32'd0);
      chk("rst_asel", {29'd0, OutASel}, 32'd0);
      Reset = 1'b1;

      // Vector table
      for (int v = 0; v < 12; v++) begin
         issue(tbl[v].op, tbl[v].dst, tbl[v].src, tbl[v].imm);
         if (v == 0) chk("accept_first_edge", s_wait, 0);
         chk($sformatf("v%0d_regsel", v), {28'd0, s_reg[1]}, {28'd0, tbl[v].reg_sel});
         chk($sformatf("v%0d_scrsel", v), {28'd0, s_scr[1]}, {28'd0, tbl[v].scr_sel});
         chk($sformatf("v%0d_funsel", v), {29'd0, s_fun[1]}, {29'd0, tbl[v].fun});
         chk($sformatf("v%0d_i", v), {16'd0, s_i[1]}, {16'd0, tbl[v].i_val});
         chk($sformatf("v%0d_latency", v), s_lat, exp_lat(tbl[v].op));
         chk($sformatf("v%0d_writes", v), s_wr, exp_wr(tbl[v].op));
         if (tbl[v].op == 3'd7)
            chk($sformatf("v%0d_readdata", v), {16'd0, ReadData}, {16'd0, tbl[v].rd});
      end

      // Swap R1 <-> S2
      issue(3'd1, 3'd0, 3'd0, 16'h1234);
      issue(3'd1, 3'd5, 3'd0, 16'hBEEF);
      issue(3'd6, 3'd5, 3'd0, 16'h0);
      chk("swp_capt_noen", {24'd0, s_reg[1], s_scr[1]}, 32'hFF);
      chk("swp_capt_asel", {29'd0, s_asel[1]}, 32'd0);
      chk("swp_capt_bsel", {29'd0, s_bsel[1]}, 32'd5);
      chk("swp_wr1_en", {24'd0, s_reg[2], s_scr[2]}, 32'hFB);
      chk("swp_wr1_i", {16'd0, s_i[2]}, 32'h1234);
      chk("swp_wr2_en", {24'd0, s_reg[3], s_scr[3]}, 32'h7F);
      chk("swp_wr2_i", {16'd0, s_i[3]}, 32'hBEEF);
      chk("swp_wr2_fun", {29'd0, s_fun[3]}, 32'd2);
      chk("swp_latency", s_lat, 4);
      chk("swp_r1", {16'd0, rf[0]}, 32'hBEEF);
      chk("swp_s2", {16'd0, rf[5]}, 32'h1234);

      // CmdValid held high through a busy command
      v0 = ref_rf[1];
      v1 = {13'd0, 3'd0};
      CmdOp = 3'd4; CmdDst = 3'd1; CmdSrc = 3'd6; CmdValid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         chk($sformatf("hold_ready_%0d", k), {31'd0, CmdReady}, (k == 2) ? 32'd1 : 32'd0);
         if (k == 1) chk("hold_done", {31'd0, Done}, 32'd1);
      end
      CmdValid = 1'b0;
      wait_idle();
      @(negedge Clock);
      chk("hold_accept_gap", acc_last - acc_prev, 3);
      apply_ref(3'd4, 3'd1, 3'd6, 16'h0);
      apply_ref(3'd4, 3'd1, 3'd6, 16'h0);
      chk("hold_r2", {16'd0, rf[1]}, {16'd0, v0 + 16'd2});

      // INC then DEC on S4 back to back; live op changes mid-command
      CmdOp = 3'd4; CmdDst = 3'd7; CmdValid = 1'b1;
      @(posedge Clock); #1 CmdOp = 3'd5;
      @(negedge Clock);
      chk("b2b_inc_scr", {28'd0, ScrSel}, 32'hE);
      chk("b2b_inc_fun", {29'd0, FunSel}, 32'd1);
      @(negedge Clock);
      @(negedge Clock);
      @(posedge Clock); #1 CmdValid = 1'b0;
      @(negedge Clock);
      chk("b2b_dec_scr", {28'd0, ScrSel}, 32'hE);
      chk("b2b_dec_fun", {29'd0, FunSel}, 32'd0);
      chk("b2b_accept_gap", acc_last - acc_prev, 3);
      wait_idle();
      @(negedge Clock);
      apply_ref(3'd4, 3'd7, 3'd0, 16'h0);
      apply_ref(3'd5, 3'd7, 3'd0, 16'h0);
      chk("b2b_s4", {16'd0, rf[7]}, {16'd0, ref_rf[7]});

      // Reset during SWP WR1
      issue(3'd1, 3'd0, 3'd0, 16'h1111);
      issue(3'd1, 3'd5, 3'd0, 16'h2222);
      issue(3'd7, 3'd0, 3'd0, 16'h0);
      chk("pre_rst_readdata", {16'd0, ReadData}, 32'h1111);
      CmdOp = 3'd6; CmdDst = 3'd5; CmdSrc = 3'd0; CmdValid = 1'b1;
      @(posedge Clock); #1 CmdValid = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      chk("wr1_scrsel", {28'd0, ScrSel}, 32'hB);
      Reset = 1'b0;
      #1;
      chk("arst_en", {24'd0, RegSel, ScrSel}, 32'hFF);
      chk("arst_readdata", {16'd0, ReadData}, 32'd0);
      chk("arst_ready", {31'd0, CmdReady}, 32'd1);
      chk("arst_fun_i", {13'd0, FunSel, I}, {13'd0, 3'd2, 16'h0});
      @(negedge Clock);
      Reset = 1'b1;
      ref_rd = 16'h0;
      chk("arst_src_untouched", {16'd0, rf[0]}, 32'h1111);
      chk("arst_dst_unwritten", {16'd0, rf[5]}, 32'h2222);
      issue(3'd0, 3'd0, 3'd0, 16'h0);
      chk("arst_accept_first_edge", s_wait, 0);

      // Reset during SWP WR2: dst already written, src left alone
      CmdOp = 3'd6; CmdDst = 3'd5; CmdSrc = 3'd0; CmdValid = 1'b1;
      @(posedge Clock); #1 CmdValid = 1'b0;
      repeat (3) @(negedge Clock);
      chk("wr2_regsel", {28'd0, RegSel}, 32'h7);
      Reset = 1'b0;
      #1;
      chk("arst2_en", {24'd0, RegSel, ScrSel}, 32'hFF);
      @(negedge Clock);
      Reset = 1'b1;
      ref_rf[5] = ref_rf[0];
      chk("arst2_dst_written", {16'd0, rf[5]}, 32'h1111);
      chk("arst2_src_untouched", {16'd0, rf[0]}, 32'h1111);

      // Random commands against the reference model
      for (int n = 0; n < 60; n++) begin
         rop  = 3'($urandom_range(7, 0));
         rdst = 3'($urandom_range(7, 0));
         rsrc = 3'($urandom_range(7, 0));
         rimm = 16'($urandom);
         issue(rop, rdst, rsrc, rimm);
         chk($sformatf("r%0d_op%0d_latency", n, rop), s_lat, exp_lat(rop));
         chk($sformatf("r%0d_op%0d_writes", n, rop), s_wr, exp_wr(rop));
         chk($sformatf("r%0d_onehot", n), s_multi, 0);
         chk($sformatf("r%0d_resp_idle", n), {s_reg[s_lat], s_scr[s_lat], s_fun[s_lat], s_i[s_lat]},
             {4'hF, 4'hF, 3'd2, 16'h0});
         chk($sformatf("r%0d_resp_sel", n), {26'd0, s_asel[s_lat], s_bsel[s_lat]}, {26'd0, rsrc, rdst});
         chk($sformatf("r%0d_readdata", n), {16'd0, ReadData}, {16'd0, ref_rd});
         for (int k = 0; k < 8; k++)
            chk($sformatf("r%0d_rf%0d", n, k), {16'd0, rf[k]}, {16'd0, ref_rf[k]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
